// File: rtl/cpu_types_pkg.sv
// Core-wide scalar types shared by the datapath packages.
// Latency: n/a (types only).
// Backpressure: n/a.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
endpackage

// File: rtl/dp_types_pkg.sv
// Datapath types for branch prediction: buffer frame, 2-bit state, tracking entry.
// Latency: n/a (types and a pure helper function).
// Backpressure: n/a.
package dp_types_pkg;
  import cpu_types_pkg::*;

  // Two taken states and two not-taken states (strong/hysteresis).
  typedef enum logic [1:0] {
    BPRED_NS = 2'b00,
    BPRED_NH = 2'b01,
    BPRED_TH = 2'b10,
    BPRED_TS = 2'b11
  } bpred_state_t;

  typedef struct packed {
    bpred_state_t state;
    word_t        target;
  } branch_pred_frame_t;

  // One in-flight prediction, kept until EX resolves it.
  typedef struct packed {
    word_t        pc;
    bpred_state_t state;
    logic         pred_taken;
    word_t        pred_npc;
  } bpred_track_t;

  function automatic logic bpred_is_taken(input bpred_state_t s);
    return (s == BPRED_TS) || (s == BPRED_TH);
  endfunction
endpackage

// File: rtl/bpred_track_fifo.sv
// In-order circular queue of in-flight predictions with push/pop/flush.
// Latency: push visible at head one cycle later; head_o is combinational from the head pointer.
// Backpressure: push ignored while full, pop ignored while empty; flush overrides both.
// Ports: CLK/nRST; push_i+wdat_i enqueue; pop_i dequeue; flush_i clears;
//        head_o oldest entry; full_o; count_o occupancy.
module bpred_track_fifo
  import cpu_types_pkg::*;
  import dp_types_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     push_i,
  input  bpred_track_t             wdat_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output bpred_track_t             head_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  bpred_track_t           mem_q [DEPTH];
  logic [PTR_W-1:0]       head_q, head_d;
  logic [PTR_W-1:0]       tail_q, tail_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[head_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & (count_q != '0);

  // Pointers are exactly log2(DEPTH) bits, so they wrap for free.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) tail_d = tail_q + 1'b1;
      if (do_pop)  head_d = head_q + 1'b1;
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (do_push && !flush_i) mem_q[tail_q] <= wdat_i;
    end
  end
endmodule

// File: rtl/branch_predict_unit.sv
// Fetch-side BTB front end: predicts next PC, tracks predictions, checks them at EX and trains the BTB.
// Latency: prediction and resolution outputs are combinational; queue/counters update on the clock edge.
// Backpressure: full tells IF to stall; a mispredict flushes the queue and blocks that cycle's push.
// Ports: CLK/nRST; fetch_valid/fetch_pc -> pred_npc/pred_taken/full; btb_rsel/btb_rdat lookup;
//        res_* from EX -> mispredict/redirect_pc; btb_wen/wsel/wdat/phit update; hit_count/miss_count.
module branch_predict_unit
  import cpu_types_pkg::*;
  import dp_types_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IDX_W = 8
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               fetch_valid,
  input  word_t              fetch_pc,
  output word_t              pred_npc,
  output logic               pred_taken,
  output logic               full,
  input  logic               res_valid,
  input  logic               res_is_branch,
  input  logic               res_taken,
  input  word_t              res_target,
  output logic               mispredict,
  output word_t              redirect_pc,
  output word_t              btb_rsel,
  input  branch_pred_frame_t btb_rdat,
  output logic               btb_wen,
  output word_t              btb_wsel,
  output branch_pred_frame_t btb_wdat,
  output logic               btb_phit,
  output word_t              hit_count,
  output word_t              miss_count
);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two and at least 2");
  end
  if (IDX_W < 1 || IDX_W > 30) begin : g_bad_idx
    $error("IDX_W must index within a 32-bit word address");
  end

  bpred_track_t              trk_in, head;
  logic [$clog2(DEPTH):0]    count;
  logic                      res_ok, act_taken;
  word_t                     hit_q, miss_q;

  // Prediction: tag-less lookup, resolution repairs aliasing later.
  assign btb_rsel   = fetch_pc;
  assign pred_taken = bpred_is_taken(btb_rdat.state);
  assign pred_npc   = pred_taken ? btb_rdat.target : fetch_pc + 32'd4;

  assign trk_in.pc         = fetch_pc;
  assign trk_in.state      = btb_rdat.state;
  assign trk_in.pred_taken = pred_taken;
  assign trk_in.pred_npc   = pred_npc;

  bpred_track_fifo #(.DEPTH(DEPTH)) u_track (
    .CLK     (CLK),
    .nRST    (nRST),
    .push_i  (fetch_valid & ~mispredict),
    .wdat_i  (trk_in),
    .pop_i   (res_valid),
    .flush_i (mispredict),
    .head_o  (head),
    .full_o  (full),
    .count_o (count)
  );

  // A resolve against an empty queue has nothing to check and is dropped.
  assign res_ok    = res_valid & (count != '0);
  assign act_taken = res_is_branch & res_taken;

  always_comb begin
    mispredict  = 1'b0;
    redirect_pc = '0;
    btb_wen     = 1'b0;
    btb_wsel    = '0;
    btb_wdat    = '0;
    btb_phit    = 1'b0;
    if (res_ok) begin
      mispredict  = (res_is_branch & (res_taken != head.pred_taken))
                  | (act_taken & (head.pred_npc != res_target))
                  | (~res_is_branch & head.pred_taken);
      redirect_pc = act_taken ? res_target : head.pc + 32'd4;
      // Non-branches that predicted taken are written too, training the alias toward not-taken.
      btb_wen         = res_is_branch | head.pred_taken;
      btb_wsel        = head.pc;
      btb_wdat.state  = head.state;
      btb_wdat.target = act_taken ? res_target : head.pred_npc;
      btb_phit        = act_taken;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (res_ok) begin
      if (mispredict) begin
        if (miss_q != '1) miss_q <= miss_q + 32'd1;
      end else begin
        if (hit_q != '1) hit_q <= hit_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
endmodule
